// File: rtl/jk_ff_arbiter_pkg.sv
// Shared types for jk_ff_arbiter: JK command encoding, sequencer states, helpers.
// Ports: none (package).
// The command encoding is chosen so that the 2-bit value is literally {j,k}.
package jk_ff_arb_pkg;

  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_cmd_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DRIVE  = 2'b01,
    SAMPLE = 2'b10
  } arb_state_e;

  // {j,k} pin values for a command.
  function automatic logic [1:0] jk_drive(input jk_cmd_e cmd);
    logic [1:0] jk;
    case (cmd)
      JK_RESET:  jk = 2'b01;
      JK_SET:    jk = 2'b10;
      JK_TOGGLE: jk = 2'b11;
      default:   jk = 2'b00;
    endcase
    return jk;
  endfunction

  // Value q takes after the flop applies a command.
  function automatic logic jk_next(input logic q, input jk_cmd_e cmd);
    logic nq;
    case (cmd)
      JK_RESET:  nq = 1'b0;
      JK_SET:    nq = 1'b1;
      JK_TOGGLE: nq = ~q;
      default:   nq = q;
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/jk_ff_arbiter_rr.sv
// Round-robin arbiter: grants the first asserted request after ptr, wrapping.
// Ports: req (N request bits), ptr (last granted index), gnt (one-hot grant, 0 if no req).
// Purely combinational; the caller owns the pointer register.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic          w_found;
  logic [PW-1:0] w_idx;

  // Walk ptr+1 .. ptr+N (mod N); the previous winner is checked last.
  always_comb begin
    gnt     = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int o = 1; o <= N; o++) begin
      w_idx = PW'((int'(ptr) + o) % N);
      if (!w_found && req[w_idx]) begin
        gnt[w_idx] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/jk_ff_arbiter.sv
// Shares one external jk_ff between N_REQ requesters: round-robin accept, drive j/k
// for one cycle, sample q, return the result tagged with the requester id (accept T -> rsp T+3).
// Ports: clk/rst (sync active-high), req_valid/req_cmd/req_ready (per-requester handshake),
// rsp_valid/rsp_id/rsp_q (result pulse), j/k/q_in (flop pins), busy, err.
// Optional macro JK_FF_ARB_CHECK_EN: tracks a predicted q and raises sticky err on mismatch;
// without it err is tied 0.
module jk_ff_arbiter
  import jk_ff_arb_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [2*N_REQ-1:0] req_cmd,
  output logic [N_REQ-1:0]   req_ready,
  output logic               rsp_valid,
  output logic [ID_W-1:0]    rsp_id,
  output logic               rsp_q,
  output logic               j,
  output logic               k,
  input  logic               q_in,
  output logic               busy,
  output logic               err
);

  arb_state_e       r_state;
  arb_state_e       w_next_state;
  logic [ID_W-1:0]  r_ptr;
  logic [ID_W-1:0]  r_gid;
  logic             r_j;
  logic             r_k;
  logic             r_rsp_valid;
  logic [ID_W-1:0]  r_rsp_id;
  logic             r_rsp_q;
  logic [N_REQ-1:0] w_gnt;
  logic [ID_W-1:0]  w_gnt_id;
  logic             w_any;
  jk_cmd_e          w_cmd;

  rr_arbiter #(
    .N  (N_REQ),
    .PW (ID_W)
  ) u_rr (
    .req (req_valid),
    .ptr (r_ptr),
    .gnt (w_gnt)
  );

  assign w_any = |req_valid;

  always_comb begin
    w_gnt_id = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt[i]) w_gnt_id = ID_W'(i);
    end
  end

  assign w_cmd = jk_cmd_e'(req_cmd[{w_gnt_id, 1'b0} +: 2]);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next_state = DRIVE;
      DRIVE:   w_next_state = SAMPLE;
      SAMPLE:  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Outputs: ready is gated by rst so nothing appears accepted in a reset cycle.
  always_comb begin
    req_ready = '0;
    if (r_state == IDLE && !rst) req_ready = w_gnt;
    busy = (r_state != IDLE);
  end

  // Datapath. j/k are loaded on the accept edge, so they are high only while in
  // DRIVE, and cleared on the DRIVE edge so SAMPLE already sees HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_j         <= 1'b0;
      r_k         <= 1'b0;
      r_gid       <= '0;
      r_ptr       <= ID_W'(N_REQ - 1);
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_q     <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            {r_j, r_k} <= jk_drive(w_cmd);
            r_gid      <= w_gnt_id;
            r_ptr      <= w_gnt_id;
          end
        end
        DRIVE: begin
          r_j <= 1'b0;
          r_k <= 1'b0;
        end
        SAMPLE: begin
          r_rsp_valid <= 1'b1;
          r_rsp_id    <= r_gid;
          r_rsp_q     <= q_in;
        end
        default: ;
      endcase
    end
  end

  assign j         = r_j;
  assign k         = r_k;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_q     = r_rsp_q;

`ifdef JK_FF_ARB_CHECK_EN
  logic r_pred;
  logic r_known;
  logic r_err;

  // Prediction advances on the accept edge; by SAMPLE the flop has applied the
  // same command, so q_in must match whenever the prediction is known.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pred  <= 1'b0;
      r_known <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (r_state == IDLE && w_any) begin
        r_pred  <= jk_next(r_pred, w_cmd);
        r_known <= r_known | (w_cmd == JK_SET) | (w_cmd == JK_RESET);
      end
      if (r_state == SAMPLE && r_known && (q_in != r_pred)) r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_jk_ff_arbiter.sv
module tb_jk_ff_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [2*N-1:0] req_cmd;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic [IW-1:0]  rsp_id;
  logic           rsp_q;
  logic           j, k;
  logic           q_in;
  logic           busy;
  logic           err;

  logic q_ff = 1'b0;   // external jk_ff (no reset)
  logic force_q0;

  always #5 clk = ~clk;

  always @(posedge clk) q_ff <= (j & k) ? ~q_ff : (j ? 1'b1 : (k ? 1'b0 : q_ff));
  assign q_in = force_q0 ? 1'b0 : q_ff;

  jk_ff_arbiter #(.N_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_cmd   (req_cmd),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_q     (rsp_q),
    .j         (j),
    .k         (k),
    .q_in      (q_in),
    .busy      (busy),
    .err       (err)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference behaviour of the flop for one command.
  function automatic logic apply_cmd(input logic q, input logic [1:0] c);
    case (c)
      2'd1:    return 1'b0;
      2'd2:    return 1'b1;
      2'd3:    return ~q;
      default: return q;
    endcase
  endfunction

  typedef struct {
    logic [IW-1:0] id;
    logic          q;
    int            due;
    logic          err_set;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] cmdq[N][$];
  logic [N-1:0] acc_mask = '0;

  int   cyc = 0;
  logic rst_q = 1'b0;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  // Reference model state
  int         last_acc = -100;
  int         ptr_m = N - 1;
  int         drive_cyc = -100;
  logic [1:0] drive_cmd = 2'b00;
  logic       ref_q = 1'b0;
  logic       known_m = 1'b0;
  logic       err_m = 1'b0;
  int         win;
  logic [N-1:0] exp_rdy;
  logic [1:0] c_m;
  exp_t       e;
  logic       exp_rv;

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst_q) begin
      sb.delete();
      last_acc = -100;
      ptr_m    = N - 1;
      known_m  = 1'b0;
      err_m    = 1'b0;
    end
    acc_mask = req_valid & req_ready;

    exp_rdy = '0;
    win = -1;
    if (!rst && (cyc - last_acc) >= 3) begin
      for (int o = 1; o <= N; o++) begin
        if (win < 0 && req_valid[(ptr_m + o) % N]) win = (ptr_m + o) % N;
      end
      if (win >= 0) exp_rdy[win] = 1'b1;
    end
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));

    if (win >= 0) begin
      c_m       = req_cmd[2*win +: 2];
      ref_q     = apply_cmd(ref_q, c_m);
      known_m   = known_m | (c_m == 2'd1) | (c_m == 2'd2);
      e.id      = IW'(win);
      e.q       = force_q0 ? 1'b0 : ref_q;
      e.due     = cyc + 3;
      e.err_set = force_q0 && known_m && ref_q;
      sb.push_back(e);
      last_acc  = cyc;
      ptr_m     = win;
      drive_cyc = cyc;
      drive_cmd = c_m;
    end

    chk("jk", 32'({j, k}), 32'((cyc == drive_cyc + 1) ? drive_cmd : 2'b00));
    chk("busy", 32'(busy), 32'((cyc - last_acc == 1) || (cyc - last_acc == 2)));

    exp_rv = (sb.size() > 0) && (sb[0].due == cyc);
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    if (exp_rv) begin
      e = sb.pop_front();
      chk("rsp_id", 32'(rsp_id), 32'(e.id));
      chk("rsp_q", 32'(rsp_q), 32'(e.q));
      if (e.err_set) err_m = 1'b1;
    end
    chk("err", 32'(err), 32'(err_m));
  end

  // Requester driver: one command at a time per requester, held until accepted.
  initial begin
    req_valid = '0;
    req_cmd   = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc_mask[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && cmdq[i].size() > 0) begin
          req_valid[i]       = 1'b1;
          req_cmd[2*i +: 2]  = cmdq[i].pop_front();
        end
      end
    end
  end

  task automatic wait_idle(input int budget);
    int  n;
    bit  done;
    n = 0;
    done = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      #1;
      done = (req_valid == '0) && (sb.size() == 0) && !busy;
      for (int i = 0; i < N; i++) if (cmdq[i].size() != 0) done = 0;
      n++;
    end
    chk("drain", 32'(done), 32'd1);
  endtask

  task automatic pulse_rst();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    int  n;
    bit  got;
    rst = 1'b1;
    force_q0 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_q", 32'(rsp_q), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Single requester: SET then RESET
    cmdq[0].push_back(2'd2);
    cmdq[0].push_back(2'd1);
    wait_idle(100);

    // Toggle chain from requester 1
    cmdq[1].push_back(2'd2);
    repeat (3) cmdq[1].push_back(2'd3);
    wait_idle(100);

    // All requesters contend
    for (int i = 0; i < N; i++) begin
      cmdq[i].push_back(2'd0);
      cmdq[i].push_back(2'(i));
    end
    wait_idle(200);

    // Sparse contention with ptr at 1
    cmdq[1].push_back(2'd3);
    wait_idle(50);
    cmdq[1].push_back(2'd2);
    cmdq[3].push_back(2'd1);
    wait_idle(50);

    // Reset while in DRIVE
    cmdq[1].push_back(2'd3);
    got = 0;
    n = 0;
    while (!got && n < 50) begin
      @(negedge clk);
      got = req_ready[1];
      n++;
    end
    chk("rstop_grant", 32'(got), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    cmdq[2].push_back(2'd2);
    cmdq[0].push_back(2'd1);
    wait_idle(50);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(3) == 0 && cmdq[i].size() < 2) cmdq[i].push_back(2'($urandom_range(3)));
      end
    end
    wait_idle(300);

`ifdef JK_FF_ARB_CHECK_EN
    // q_in stuck at 0: unknown toggle stays clean, SET then flags sticky err
    pulse_rst();
    force_q0 = 1'b1;
    cmdq[2].push_back(2'd3);
    wait_idle(50);
    cmdq[2].push_back(2'd2);
    wait_idle(50);
    cmdq[2].push_back(2'd0);
    wait_idle(50);
    force_q0 = 1'b0;
    pulse_rst();
    repeat (2) @(posedge clk);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t expected < 2000000", $time);
    $fatal(1);
  end

endmodule
